gencon_param: RTL and testbench
===============================

// Module: gencon_param
// PURPOSE
//  Parametrised keypad calculator controller; generalises gencon to WIDTH-bit signed operands.
//  Takes decimal digit keypresses, sign/operator keys and '=' and computes add/sub/mul.
//  Multiply is sequential; results can be chained. Flags overflow. Drives display_output directly.
// PARAMETERS
//  WIDTH       16  operand/result width, two's complement, >=8
//  MAX_DIGITS  5   max decimal digits per operand; further digit presses ignored
// PORTS
//  clk               in   1      system clock, rising edge
//  nRST              in   1      asynchronous active-low reset
//  keypad_input      in   4      BCD digit; values 10..15 ignored
//  read_input        in   1      digit strobe; one digit taken per 0->1 edge
//  operator_input    in   3      001 add/negate, 010 sub, 100 mul, 110 div (macro only); 000 idle
//  equal_input       in   1      '=' level; sampled only in ENTRY_B
//  clear_input       in   1      synchronous clear to ENTRY_A
//  complete          out  1      high while in DONE
//  busy              out  1      high while in COMPUTE
//  overflow          out  1      sticky until next ENTRY_A/clear: entry or result out of range
//  display_output    out  WIDTH  current operand (entry) or result (DONE), two's complement
//  tb_current_state  out  3      state encoding below, for benches
// BEHAVIOUR
//  Reset: all outputs 0, state ENTRY_A, operands/op/neg flags cleared. Applies at any time,
//   including mid-COMPUTE; in-flight result discarded.
//  States: 0 ENTRY_A, 1 OP_LATCH, 3 ENTRY_B, 4 COMPUTE, 5 DONE (2,6,7 unused -> ENTRY_A).
//  Digit entry (ENTRY_A/ENTRY_B only): on read_input rising edge, mag <= mag*10 + digit.
//   Take at most MAX_DIGITS digits.
//   mag > 2^(WIDTH-1)-1 (or > 2^(WIDTH-1) when negative) -> set overflow, mag wraps to WIDTH.
//  Negate: 001 while the operand has zero digits entered toggles its neg flag.
//   Display shows -0 as 0.
//  ENTRY_A + nonzero op after >=1 digit -> latch op, go OP_LATCH (1 cycle).
//   Then ENTRY_B once operator_input returns to 000. Invalid codes ignored.
//  Operator input must be 000 for one cycle before a 001 in ENTRY_B is taken as negate.
//  ENTRY_B + equal_input with >=1 digit -> COMPUTE. equal_input with 0 digits is ignored.
//  COMPUTE latency, equal sampled to complete high:
//   add/sub: 2 cycles.
//   mul: WIDTH+2 cycles, shift-add on magnitudes, sign applied at end.
//  Result truncated to WIDTH bits.
//   overflow set if true result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  DONE: complete=1, display holds result.
//   read_input edge -> new ENTRY_A, digit taken as first digit.
//   Nonzero op -> result becomes operand A, go OP_LATCH (chaining).
//  clear_input has priority over every other input in the same cycle.
//   It zeroes operands and flags and goes to ENTRY_A next cycle.
//  read_input edge coincident with an operator key: operator wins, digit dropped.
//  display_output during entry: signed current operand. In OP_LATCH: operand A.
// CONFIGURATION
//  GENCON_DIV_EN defined: op 110 = signed divide.
//   Restoring divider, WIDTH+2 cycles, quotient truncated toward zero.
//   Divide by 0 -> result 0, overflow=1. -2^(WIDTH-1)/-1 -> overflow=1, result wraps.
//  GENCON_DIV_EN undefined: 110 treated as invalid code, ignored. No divider logic present.
// TESTING
//  2, 001, 3, '=' -> complete after 2 cycles, display 5, overflow 0
//  neg, 3, 010, 5, '=' -> display -8 (16'hFFF8)
//  neg, 3, 100, neg, 6, '=' -> complete after WIDTH+2 cycles, display 18
//  128, 100, 256, '=' -> display 16'h8000, overflow 1
//  7, 001, 2, '=', then 100, 3, '=' (chained) -> 27
//  nRST low during mul COMPUTE -> outputs 0, state 0 next edge
//  With GENCON_DIV_EN: -7/2 -> -3; 5/0 -> 0, overflow 1

Source files
------------

// File: rtl/gencon_param_if.sv
// Keypad, operator and display bundle for gencon_param.
// The master side is the keypad/bench and the slave side is the controller.
interface gencon_param_if #(parameter int WIDTH = 16);
  logic [3:0]       keypad_input;
  logic             read_input;
  logic [2:0]       operator_input;
  logic             equal_input;
  logic             clear_input;
  logic             complete;
  logic             busy;
  logic             overflow;
  logic [WIDTH-1:0] display_output;
  logic [2:0]       tb_current_state;

  modport master (output keypad_input, read_input, operator_input, equal_input, clear_input,
                  input  complete, busy, overflow, display_output, tb_current_state);
  modport slave  (input  keypad_input, read_input, operator_input, equal_input, clear_input,
                  output complete, busy, overflow, display_output, tb_current_state);
endinterface

// File: rtl/gencon_param.sv
// Keypad calculator controller: signed WIDTH-bit add/sub, sequential shift-add multiply, chaining.
// Optional feature macro: GENCON_DIV_EN adds op 110 as a restoring signed divider.
module gencon_param #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input logic           clk,
  input logic           nRST,
  gencon_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 3);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]    LAST_ADD = CW'(1);
  localparam logic [CW-1:0]    LAST_SEQ = CW'(WIDTH + 1);
  localparam logic [CW-1:0]    STEPS    = CW'(WIDTH);
  localparam logic [DW-1:0]    MAXD     = DW'(MAX_DIGITS);
  localparam logic [WIDTH-1:0] POS_LIM  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_MUL = 3'b100, OP_DIV = 3'b110;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0, ST_OP_LATCH = 3'd1, ST_ENTRY_B = 3'd3, ST_COMPUTE = 3'd4, ST_DONE = 3'd5
  } state_t;

  function automatic logic [WIDTH-1:0] f_signed(input logic [WIDTH-1:0] mag, input logic neg);
    f_signed = neg ? ('0 - mag) : mag;
  endfunction

  function automatic logic [WIDTH+1:0] f_sext(input logic [WIDTH-1:0] mag, input logic neg);
    f_sext = neg ? ('0 - {2'b00, mag}) : {2'b00, mag};
  endfunction

  // Returns {overflow, wrapped magnitude} for one more decimal digit.
  function automatic logic [WIDTH:0] f_entry(input logic [WIDTH-1:0] mag, input logic neg,
                                             input logic [3:0] digit);
    logic [WIDTH+3:0] ext;
    logic [WIDTH+3:0] lim;
    ext = ({4'b0000, mag} << 3) + ({4'b0000, mag} << 1) + {{WIDTH{1'b0}}, digit};
    lim = {4'b0000, POS_LIM} + {{(WIDTH+3){1'b0}}, neg};
    f_entry = {(ext > lim), ext[WIDTH-1:0]};
  endfunction

  function automatic logic f_exceeds(input logic [2*WIDTH-1:0] mag, input logic neg);
    f_exceeds = mag > ({{WIDTH{1'b0}}, POS_LIM} + {{(2*WIDTH-1){1'b0}}, neg});
  endfunction

  state_t              r_state, w_state;
  logic [WIDTH-1:0]    r_mag_a, w_mag_a, r_mag_b, w_mag_b, r_res, w_res, r_q, w_q, r_disp, w_disp;
  logic                r_neg_a, w_neg_a, r_neg_b, w_neg_b, r_ovf, w_ovf;
  logic [DW-1:0]       r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
  logic [2:0]          r_op, w_op;
  logic [CW-1:0]       r_cyc, w_cyc, w_last;
  logic [2*WIDTH-1:0]  r_acc, w_acc, r_sh, w_sh;
  logic                r_read_d, r_op_idle, r_complete, r_busy;
  logic                w_digit_ok, w_neg_press, w_op_valid, w_sign, w_fin_ovf;
  logic [WIDTH-1:0]    w_fin_res;
  logic [WIDTH+1:0]    w_sa, w_sb, w_sum;
  logic [WIDTH:0]      w_cur;
`ifdef GENCON_DIV_EN
  logic [WIDTH:0]      w_rem;
`endif

  // Next-state, datapath and display computation.
  always_comb begin
    w_state = r_state;  w_mag_a = r_mag_a;  w_mag_b = r_mag_b;  w_neg_a = r_neg_a;
    w_neg_b = r_neg_b;  w_cnt_a = r_cnt_a;  w_cnt_b = r_cnt_b;  w_op = r_op;
    w_ovf = r_ovf;      w_res = r_res;      w_cyc = r_cyc;      w_acc = r_acc;
    w_sh = r_sh;        w_q = r_q;
`ifdef GENCON_DIV_EN
    w_rem = '0;
`endif
    w_digit_ok  = bus.read_input & ~r_read_d & (bus.keypad_input < 4'd10);
    w_neg_press = (bus.operator_input == OP_ADD) & r_op_idle;
    w_op_valid  = (bus.operator_input == OP_ADD) || (bus.operator_input == OP_SUB) ||
                  (bus.operator_input == OP_MUL);
`ifdef GENCON_DIV_EN
    w_op_valid  = w_op_valid || (bus.operator_input == OP_DIV);
`endif
    w_cur  = (r_state == ST_ENTRY_B) ? f_entry(r_mag_b, r_neg_b, bus.keypad_input)
                                     : f_entry(r_mag_a, r_neg_a, bus.keypad_input);
    w_sa   = f_sext(r_mag_a, r_neg_a);
    w_sb   = f_sext(r_mag_b, r_neg_b);
    w_sum  = (r_op == OP_SUB) ? (w_sa - w_sb) : (w_sa + w_sb);
    w_sign = r_neg_a ^ r_neg_b;
    w_last = ((r_op == OP_ADD) || (r_op == OP_SUB)) ? LAST_ADD : LAST_SEQ;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_fin_res = w_sum[WIDTH-1:0];
        w_fin_ovf = (w_sum[WIDTH+1:WIDTH-1] != 3'b000) && (w_sum[WIDTH+1:WIDTH-1] != 3'b111);
      end
      OP_MUL: begin
        w_fin_res = f_signed(r_acc[WIDTH-1:0], w_sign);
        w_fin_ovf = f_exceeds(r_acc, w_sign);
      end
`ifdef GENCON_DIV_EN
      OP_DIV: begin
        w_fin_res = (r_mag_b == '0) ? '0 : f_signed(r_q, w_sign);
        w_fin_ovf = (r_mag_b == '0) || f_exceeds({{WIDTH{1'b0}}, r_q}, w_sign);
      end
`endif
      default: begin
        w_fin_res = '0;
        w_fin_ovf = 1'b0;
      end
    endcase

    if (bus.clear_input) begin
      w_state = ST_ENTRY_A;  w_mag_a = '0;  w_mag_b = '0;  w_neg_a = 1'b0;  w_neg_b = 1'b0;
      w_cnt_a = '0;  w_cnt_b = '0;  w_op = 3'b000;  w_ovf = 1'b0;  w_res = '0;
    end else begin
      case (r_state)
        ST_ENTRY_A: begin
          if (bus.operator_input != 3'b000) begin
            if ((r_cnt_a != '0) && w_op_valid) begin
              w_op    = bus.operator_input;
              w_state = ST_OP_LATCH;
            end else if ((r_cnt_a == '0) && w_neg_press) begin
              w_neg_a = ~r_neg_a;
            end else begin
              w_op = r_op;
            end
          end else if (w_digit_ok && (r_cnt_a < MAXD)) begin
            w_mag_a = w_cur[WIDTH-1:0];
            w_ovf   = r_ovf | w_cur[WIDTH];
            w_cnt_a = r_cnt_a + DW'(1);
          end else begin
            w_mag_a = r_mag_a;
          end
        end
        ST_OP_LATCH: begin
          if (bus.operator_input == 3'b000) begin
            w_state = ST_ENTRY_B;  w_mag_b = '0;  w_neg_b = 1'b0;  w_cnt_b = '0;
          end else begin
            w_state = r_state;
          end
        end
        ST_ENTRY_B: begin
          if (bus.operator_input != 3'b000) begin
            if ((r_cnt_b == '0) && w_neg_press) w_neg_b = ~r_neg_b;
            else                                w_neg_b = r_neg_b;
          end else if (bus.equal_input && (r_cnt_b != '0)) begin
            w_state = ST_COMPUTE;  w_cyc = '0;  w_acc = '0;
            w_sh    = {{WIDTH{1'b0}}, r_mag_a};
            w_q     = (r_op == OP_DIV) ? r_mag_a : r_mag_b;
          end else if (w_digit_ok && (r_cnt_b < MAXD)) begin
            w_mag_b = w_cur[WIDTH-1:0];
            w_ovf   = r_ovf | w_cur[WIDTH];
            w_cnt_b = r_cnt_b + DW'(1);
          end else begin
            w_mag_b = r_mag_b;
          end
        end
        ST_COMPUTE: begin
          w_cyc = r_cyc + CW'(1);
          if (r_cyc == w_last) begin
            w_state = ST_DONE;
            w_res   = w_fin_res;
            w_ovf   = r_ovf | w_fin_ovf;
          end else if (r_cyc < STEPS) begin
`ifdef GENCON_DIV_EN
            if (r_op == OP_DIV) begin
              w_rem = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
              if (w_rem >= {1'b0, r_mag_b}) begin
                w_acc = {{(WIDTH-1){1'b0}}, w_rem - {1'b0, r_mag_b}};
                w_q   = {r_q[WIDTH-2:0], 1'b1};
              end else begin
                w_acc = {{(WIDTH-1){1'b0}}, w_rem};
                w_q   = {r_q[WIDTH-2:0], 1'b0};
              end
            end else begin
              w_acc = r_q[0] ? (r_acc + r_sh) : r_acc;
              w_sh  = r_sh << 1;
              w_q   = r_q >> 1;
            end
`else
            w_acc = r_q[0] ? (r_acc + r_sh) : r_acc;
            w_sh  = r_sh << 1;
            w_q   = r_q >> 1;
`endif
          end else begin
            w_acc = r_acc;
          end
        end
        ST_DONE: begin
          if (bus.operator_input != 3'b000) begin
            if (w_op_valid) begin
              // Chaining: the signed result becomes a fully entered operand A.
              w_op    = bus.operator_input;
              w_mag_a = r_res[WIDTH-1] ? ('0 - r_res) : r_res;
              w_neg_a = r_res[WIDTH-1];
              w_cnt_a = DW'(1);
              w_state = ST_OP_LATCH;
            end else begin
              w_op = r_op;
            end
          end else if (bus.read_input && !r_read_d) begin
            w_state = ST_ENTRY_A;  w_neg_a = 1'b0;  w_mag_b = '0;  w_neg_b = 1'b0;
            w_cnt_b = '0;  w_op = 3'b000;  w_ovf = 1'b0;
            w_mag_a = w_digit_ok ? WIDTH'(bus.keypad_input) : '0;
            w_cnt_a = w_digit_ok ? DW'(1) : DW'(0);
          end else begin
            w_state = r_state;
          end
        end
        default: begin
          w_state = ST_ENTRY_A;  w_mag_a = '0;  w_mag_b = '0;  w_neg_a = 1'b0;  w_neg_b = 1'b0;
          w_cnt_a = '0;  w_cnt_b = '0;  w_op = 3'b000;  w_ovf = 1'b0;
        end
      endcase
    end

    case (w_state)
      ST_ENTRY_A, ST_OP_LATCH: w_disp = f_signed(w_mag_a, w_neg_a);
      ST_ENTRY_B:              w_disp = f_signed(w_mag_b, w_neg_b);
      ST_COMPUTE:              w_disp = r_disp;
      ST_DONE:                 w_disp = w_res;
      default:                 w_disp = '0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_ENTRY_A;  r_mag_a <= '0;  r_mag_b <= '0;  r_neg_a <= 1'b0;  r_neg_b <= 1'b0;
      r_cnt_a <= '0;  r_cnt_b <= '0;  r_op <= 3'b000;  r_ovf <= 1'b0;  r_res <= '0;
      r_cyc <= '0;  r_acc <= '0;  r_sh <= '0;  r_q <= '0;  r_disp <= '0;
      r_read_d <= 1'b0;  r_op_idle <= 1'b1;  r_complete <= 1'b0;  r_busy <= 1'b0;
    end else begin
      r_state <= w_state;  r_mag_a <= w_mag_a;  r_mag_b <= w_mag_b;  r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;  r_cnt_a <= w_cnt_a;  r_cnt_b <= w_cnt_b;  r_op <= w_op;
      r_ovf <= w_ovf;  r_res <= w_res;  r_cyc <= w_cyc;  r_acc <= w_acc;  r_sh <= w_sh;
      r_q <= w_q;  r_disp <= w_disp;  r_read_d <= bus.read_input;
      r_op_idle  <= (bus.operator_input == 3'b000);
      r_complete <= (w_state == ST_DONE);
      r_busy     <= (w_state == ST_COMPUTE);
    end
  end

  assign bus.complete         = r_complete;
  assign bus.busy             = r_busy;
  assign bus.overflow         = r_ovf;
  assign bus.display_output   = r_disp;
  assign bus.tb_current_state = r_state;
endmodule

// File: tb/tb_gencon_param.sv
// Randomised keypad sessions for gencon_param checked against an integer-arithmetic calculator model.
module tb_gencon_param;
  localparam int     W    = 16;
  localparam int     MAXD = 5;
  localparam longint HALF = longint'(1) << (W - 1);

  logic clk = 1'b0;
  logic nRST;
  gencon_param_if #(.WIDTH(W)) bus ();
  gencon_param #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (.clk(clk), .nRST(nRST), .bus(bus.slave));

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cur_mag, a_val, b_val;
  bit     cur_neg, m_ovf;
  int     cur_cnt;
  logic [W-1:0] m_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] wrapw(input longint v);
    wrapw = v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input int d);
    bus.keypad_input = 4'(d);
    bus.read_input   = 1'b1;
    tick();
    bus.read_input   = 1'b0;
    tick();
  endtask

  task automatic press_op(input logic [2:0] c);
    bus.operator_input = c;
    tick();
    bus.operator_input = 3'b000;
    tick();
  endtask

  task automatic do_clear();
    bus.clear_input = 1'b1;
    tick();
    bus.clear_input = 1'b0;
    check("clr_state", 64'(bus.tb_current_state), 64'(0));
    check("clr_disp", 64'(bus.display_output), 64'(0));
    check("clr_ovf", 64'(bus.overflow), 64'(0));
  endtask

  task automatic key_digit(input int d);
    press_digit(d);
    if (cur_cnt < MAXD) begin
      cur_mag = cur_mag * 10 + d;
      cur_cnt++;
      if (cur_mag > (cur_neg ? HALF : HALF - 1)) begin
        m_ovf   = 1'b1;
        cur_mag = cur_mag % (2 * HALF);
      end
    end
    check("entry_disp", 64'(bus.display_output), 64'(wrapw(cur_neg ? -cur_mag : cur_mag)));
  endtask

  task automatic enter_operand(input bit neg, input int nd, input longint val);
    cur_mag = 0;
    cur_neg = 1'b0;
    cur_cnt = 0;
    if (neg) begin
      press_op(3'b001);
      cur_neg = 1'b1;
      check("neg_disp", 64'(bus.display_output), 64'(0));
    end
    for (int i = nd - 1; i >= 0; i--) key_digit(int'((val / (10 ** i)) % 10));
  endtask

  task automatic do_equal(input logic [2:0] op);
    longint t;
    int     lat;
    bit     dz;
    dz = 1'b0;
    bus.equal_input = 1'b1;
    tick();
    bus.equal_input = 1'b0;
    check("busy_start", 64'(bus.busy), 64'(1));
    lat = 1;
    tick();
    while (!bus.complete && lat < 4 * W) begin
      check("busy", 64'(bus.busy), 64'(1));
      tick();
      lat++;
    end
    case (op)
      3'b001:  t = a_val + b_val;
      3'b010:  t = a_val - b_val;
      3'b100:  t = a_val * b_val;
      default: begin
        if (b_val == 0) begin t = 0; dz = 1'b1; end
        else t = a_val / b_val;
      end
    endcase
    if (dz || t > HALF - 1 || t < -HALF) m_ovf = 1'b1;
    m_res = wrapw(t);
    check("latency", 64'(lat), 64'((op == 3'b001 || op == 3'b010) ? 2 : W + 2));
    check("complete", 64'(bus.complete), 64'(1));
    check("busy_end", 64'(bus.busy), 64'(0));
    check("done_state", 64'(bus.tb_current_state), 64'(5));
    check("result", 64'(bus.display_output), 64'(m_res));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  task automatic run_txn(input bit uc, input bit na, input int nda, input longint va,
                         input logic [2:0] op, input bit nb, input int ndb, input longint vb);
    if (uc) do_clear();
    m_ovf = 1'b0;
    enter_operand(na && uc, nda, va);
    a_val = cur_neg ? -cur_mag : cur_mag;
    press_op(op);
    check("b_state", 64'(bus.tb_current_state), 64'(3));
    check("b_disp", 64'(bus.display_output), 64'(0));
    enter_operand(nb, ndb, vb);
    b_val = cur_neg ? -cur_mag : cur_mag;
    do_equal(op);
  endtask

  task automatic chain(input logic [2:0] op, input bit nb, input int ndb, input longint vb);
    logic signed [W-1:0] s;
    bus.operator_input = op;
    tick();
    check("chain_state", 64'(bus.tb_current_state), 64'(1));
    check("chain_disp", 64'(bus.display_output), 64'(m_res));
    bus.operator_input = 3'b000;
    tick();
    check("chain_b", 64'(bus.tb_current_state), 64'(3));
    s     = m_res;
    a_val = s;
    enter_operand(nb, ndb, vb);
    b_val = cur_neg ? -cur_mag : cur_mag;
    do_equal(op);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    bit         na, nb, uc;
    int         nda, ndb;
    nRST = 1'b0;
    bus.keypad_input = 4'd0;  bus.read_input = 1'b0;  bus.operator_input = 3'b000;
    bus.equal_input = 1'b0;   bus.clear_input = 1'b0;
    tick();
    tick();
    check("rst_state", 64'(bus.tb_current_state), 64'(0));
    check("rst_disp", 64'(bus.display_output), 64'(0));
    check("rst_complete", 64'(bus.complete), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    nRST = 1'b1;
    tick();

    run_txn(1'b1, 1'b0, 1, 2, 3'b001, 1'b0, 1, 3);
    check("spec_add", 64'(bus.display_output), 64'(5));
    run_txn(1'b1, 1'b1, 1, 3, 3'b010, 1'b0, 1, 5);
    check("spec_sub", 64'(bus.display_output), 64'(16'hFFF8));
    run_txn(1'b1, 1'b1, 1, 3, 3'b100, 1'b1, 1, 6);
    check("spec_mul", 64'(bus.display_output), 64'(18));
    run_txn(1'b1, 1'b0, 3, 128, 3'b100, 1'b0, 3, 256);
    check("spec_movf", 64'(bus.display_output), 64'(16'h8000));
    check("spec_movf_flag", 64'(bus.overflow), 64'(1));
    run_txn(1'b1, 1'b0, 1, 7, 3'b001, 1'b0, 1, 2);
    chain(3'b100, 1'b0, 1, 3);
    check("spec_chain", 64'(bus.display_output), 64'(27));
`ifdef GENCON_DIV_EN
    run_txn(1'b1, 1'b1, 1, 7, 3'b110, 1'b0, 1, 2);
    check("spec_div", 64'(bus.display_output), 64'(16'hFFFD));
    run_txn(1'b1, 1'b0, 1, 5, 3'b110, 1'b0, 1, 0);
    check("spec_div0", 64'(bus.display_output), 64'(0));
    check("spec_div0_flag", 64'(bus.overflow), 64'(1));
`endif

    // '=' with no digits for B is ignored.
    do_clear();
    enter_operand(1'b0, 1, 4);
    press_op(3'b001);
    bus.equal_input = 1'b1;
    tick();
    bus.equal_input = 1'b0;
    check("eq_nodig", 64'(bus.tb_current_state), 64'(3));

    // Operator and digit edge together: operator wins.
    do_clear();
    enter_operand(1'b0, 1, 9);
    bus.keypad_input = 4'd5;  bus.read_input = 1'b1;  bus.operator_input = 3'b010;
    tick();
    check("opwin_state", 64'(bus.tb_current_state), 64'(1));
    check("opwin_disp", 64'(bus.display_output), 64'(9));
    bus.read_input = 1'b0;  bus.operator_input = 3'b000;
    tick();
    check("opwin_b", 64'(bus.tb_current_state), 64'(3));

    // Clear beats a simultaneous digit and '='.
    enter_operand(1'b0, 1, 2);
    bus.clear_input = 1'b1;  bus.read_input = 1'b1;  bus.keypad_input = 4'd7;  bus.equal_input = 1'b1;
    tick();
    check("clrpri_state", 64'(bus.tb_current_state), 64'(0));
    check("clrpri_disp", 64'(bus.display_output), 64'(0));
    bus.clear_input = 1'b0;  bus.read_input = 1'b0;  bus.equal_input = 1'b0;
    tick();

    // Digit cap and non-decimal keys.
    enter_operand(1'b0, 6, 123456);
    check("digit_cap", 64'(bus.display_output), 64'(12345));
    press_digit(12);
    check("bad_digit", 64'(bus.display_output), 64'(12345));

    // Reset in the middle of a multiply.
    do_clear();
    enter_operand(1'b0, 3, 123);
    press_op(3'b100);
    enter_operand(1'b0, 2, 45);
    bus.equal_input = 1'b1;
    tick();
    bus.equal_input = 1'b0;
    tick();
    tick();
    check("mid_busy", 64'(bus.busy), 64'(1));
    nRST = 1'b0;
    #1;
    check("mid_rst_state", 64'(bus.tb_current_state), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_disp", 64'(bus.display_output), 64'(0));
    tick();
    check("mid_rst_complete", 64'(bus.complete), 64'(0));
    check("mid_rst_state2", 64'(bus.tb_current_state), 64'(0));
    nRST = 1'b1;
    tick();

    for (int t = 0; t < 30; t++) begin
      na = 1'($urandom_range(0, 1));
      nb = 1'($urandom_range(0, 1));
      uc = (t == 0) || na || ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       op = 3'b001;
        1:       op = 3'b010;
        default: op = 3'b100;
      endcase
      nda = int'($urandom_range(1, 6));
      ndb = int'($urandom_range(1, 6));
      run_txn(uc, na, nda, longint'($urandom_range(0, 10 ** nda - 1)),
              op, nb, ndb, longint'($urandom_range(0, 10 ** ndb - 1)));
      if ($urandom_range(0, 2) == 0) begin
        ndb = int'($urandom_range(1, 3));
        chain(($urandom_range(0, 1) == 1) ? 3'b100 : 3'b010, 1'($urandom_range(0, 1)), ndb,
              longint'($urandom_range(0, 10 ** ndb - 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
